// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiplier and restoring divider.
// Busy stalls the PC from the Start cycle until the results are ready.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTING,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    count;
    logic             is_div;
    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] mag_m;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] raw1;

    logic             load;
    logic             finish;
    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] op1_mag;
    logic [WIDTH-1:0] op2_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin1;
    logic [WIDTH-1:0]   fin2;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        load       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    Busy       = 1'b1;
                    load       = 1'b1;
                    state_next = COMPUTING;
                end
            end
            COMPUTING: begin
                Busy = 1'b1;
                if (count == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Start may still be high while Reset is held; never stall then.
        if (Reset) begin
            Busy = 1'b0;
        end
    end

    always_comb begin
        op1_neg = MCycleOp[1] & Operand1[WIDTH-1];
        op2_neg = MCycleOp[1] & Operand2[WIDTH-1];
        op1_mag = op1_neg ? -Operand1 : Operand1;
        op2_mag = op2_neg ? -Operand2 : Operand2;
    end

    // One iteration: mul adds then shifts right, div shifts left then trial-subtracts.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_m} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, mag_m};
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                step_hi = diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = shifted[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod = {step_hi, step_lo};
        if (sign1 ^ sign2) begin
            prod = -prod;
        end
        quo  = (sign1 ^ sign2) ? -step_lo : step_lo;
        rem  = sign1 ? -step_hi : step_hi;
        fin1 = prod[WIDTH-1:0];
        fin2 = prod[2*WIDTH-1:WIDTH];
        if (is_div) begin
            if (mag_m == '0) begin
                fin1 = '1;
                fin2 = raw1;
            end else begin
                fin1 = quo;
                fin2 = rem;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count   <= '0;
            is_div  <= 1'b0;
            sign1   <= 1'b0;
            sign2   <= 1'b0;
            mag_m   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            raw1    <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else if (load) begin
            count  <= '0;
            is_div <= MCycleOp[0];
            sign1  <= op1_neg;
            sign2  <= op2_neg;
            raw1   <= Operand1;
            acc_hi <= '0;
            if (MCycleOp[0]) begin
                mag_m  <= op2_mag;
                acc_lo <= op1_mag;
            end else begin
                mag_m  <= op1_mag;
                acc_lo <= op2_mag;
            end
        end else if (state == COMPUTING) begin
            count  <= count + 1'b1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (finish) begin
                Result1 <= fin1;
                Result2 <= fin2;
            end
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed and randomized checks of mcycle_unit
// against a plain-arithmetic reference model.
module tb_mcycle_unit;

    logic        CLK;
    logic        Reset;
    logic        Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .Start(Start),
        .MCycleOp(MCycleOp),
        .Operand1(Operand1),
        .Operand2(Operand2),
        .Result1(Result1),
        .Result2(Result2),
        .Busy(Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model(input logic [1:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r1,
                                  output logic [31:0] r2);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[0]) begin
            if (op[1]) p = 64'(sa * sb);
            else p = {32'd0, a} * {32'd0, b};
            r1 = p[31:0];
            r2 = p[63:32];
        end else if (b == 32'd0) begin
            r1 = 32'hFFFF_FFFF;
            r2 = a;
        end else if (op[1]) begin
            q  = sa / sb;
            r  = sa % sb;
            r1 = q[31:0];
            r2 = r[31:0];
        end else begin
            r1 = a / b;
            r2 = a % b;
        end
    endfunction

    // Drives one op starting at the next falling edge, scrambles the
    // inputs while computing, and returns results from the first Busy-low cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold,
                          output logic [31:0] r1, output logic [31:0] r2,
                          output int nbusy);
        @(negedge CLK);
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        #1;
        nbusy = Busy ? 1 : 0;
        for (int c = 1; c < 200; c++) begin
            @(negedge CLK);
            if (!Busy) break;
            nbusy++;
            if (c == 1) begin
                Operand1 = $urandom;
                Operand2 = $urandom;
                MCycleOp = 2'($urandom);
            end
        end
        r1 = Result1;
        r2 = Result2;
        if (!hold) Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset    = 1'b1;
        Start    = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = '0;
        Operand2 = '0;
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", Busy);
        end
        checks++;
        if (Result1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_r1: got %h expected 0", Result1);
        end
        checks++;
        if (Result2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_r2: got %h expected 0", Result2);
        end
        Reset = 1'b0;
    endtask

    task automatic test_directed(input string name, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] e1, input logic [31:0] e2);
        logic [31:0] r1, r2;
        int nb;
        run_op(op, a, b, 1'b0, r1, r2, nb);
        checks++;
        if (nb !== 33) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d expected 33", name, nb);
        end
        checks++;
        if (r1 !== e1) begin
            errors++;
            $display("FAIL %s_r1: got %h expected %h", name, r1, e1);
        end
        checks++;
        if (r2 !== e2) begin
            errors++;
            $display("FAIL %s_r2: got %h expected %h", name, r2, e2);
        end
    endtask

    task automatic test_start_hold();
        logic [31:0] r1, r2;
        int nb;
        run_op(2'b00, 32'd5, 32'd9, 1'b1, r1, r2, nb);
        checks++;
        if (r1 !== 32'd45 || nb !== 33) begin
            errors++;
            $display("FAIL hold_op: got %h/%0d expected 0000002d/33", r1, nb);
        end
        @(posedge CLK);
        #1;
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (Busy !== 1'b0) begin
                errors++;
                $display("FAIL hold_busy_%0d: got %b expected 0", i, Busy);
            end
        end
        checks++;
        if (Result1 !== 32'd45 || Result2 !== 32'd0) begin
            errors++;
            $display("FAIL hold_results: got %h/%h expected 0000002d/00000000",
                     Result1, Result2);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        Start    = 1'b1;
        MCycleOp = 2'b00;
        Operand1 = 32'h1234_5678;
        Operand2 = 32'h9ABC_DEF0;
        repeat (10) @(negedge CLK);
        Reset = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy: got %b expected 0", Busy);
        end
        checks++;
        if (Result1 !== 32'd0 || Result2 !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_results: got %h/%h expected 0/0", Result1, Result2);
        end
        @(negedge CLK);
        Reset = 1'b0;
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (Busy !== 1'b0 || Result1 !== 32'd0) begin
                errors++;
                $display("FAIL rstmid_idle_%0d: got %b/%h expected 0/0", i, Busy, Result1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2, e1, e2;
        int nb;
        for (int k = 0; k < 2; k++) begin
            logic [1:0] op;
            logic [31:0] a, b;
            op = (k == 0) ? 2'b11 : 2'b10;
            a  = (k == 0) ? 32'hFFFF_FF9C : 32'hFFFF_FFF6;
            b  = (k == 0) ? 32'd9 : 32'hFFFF_FFF6;
            model(op, a, b, e1, e2);
            run_op(op, a, b, 1'b0, r1, r2, nb);
            checks++;
            if (nb !== 33 || r1 !== e1 || r2 !== e2) begin
                errors++;
                $display("FAIL b2b_%0d: got %0d %h %h expected 33 %h %h",
                         k, nb, r1, r2, e1, e2);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r1, r2, e1, e2, a, b;
        logic [1:0] op;
        int nb, sel;
        for (int n = 0; n < 60; n++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin
                a  = 32'h8000_0000;
                b  = 32'hFFFF_FFFF;
                op = 2'b11;
            end
            if (sel == 2) begin
                a = $urandom_range(0, 1000);
                b = $urandom_range(1, 30);
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            model(op, a, b, e1, e2);
            run_op(op, a, b, 1'b0, r1, r2, nb);
            checks++;
            if (nb !== 33) begin
                errors++;
                $display("FAIL rand_busy_%0d: got %0d expected 33", n, nb);
            end
            checks++;
            if (r1 !== e1 || r2 !== e2) begin
                errors++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h: got %h %h expected %h %h",
                         n, op, a, b, r1, r2, e1, e2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed("umul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'h0000_0001, 32'hFFFF_FFFE);
        test_directed("smul", 2'b10, 32'hFFFF_FFFD, 32'd7,
                      32'hFFFF_FFEB, 32'hFFFF_FFFF);
        test_directed("udiv", 2'b01, 32'd100, 32'd7, 32'd14, 32'd2);
        test_directed("sdiv_negdvd", 2'b11, 32'hFFFF_FF9C, 32'd7,
                      32'hFFFF_FFF2, 32'hFFFF_FFFE);
        test_directed("sdiv_negdvs", 2'b11, 32'd100, 32'hFFFF_FFF9,
                      32'hFFFF_FFF2, 32'd2);
        test_directed("div_zero", 2'b01, 32'h1234_5678, 32'd0,
                      32'hFFFF_FFFF, 32'h1234_5678);
        test_directed("sdiv_zero", 2'b11, 32'h8765_4321, 32'd0,
                      32'hFFFF_FFFF, 32'h8765_4321);
        test_directed("sdiv_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                      32'h8000_0000, 32'd0);
        test_start_hold();
        test_reset_mid();
        test_directed("after_reset", 2'b00, 32'd6, 32'd7, 32'd42, 32'd0);
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
